delta_sigma: RTL and testbench



---
 rtl/delta_sigma_if.sv | 11 +
 rtl/delta_sigma.sv | 41 ++++
 tb/tb_delta_sigma.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/delta_sigma_if.sv
// Sample/bitstream bundle for the first-order delta-sigma DAC.
// master drives the signed sample, slave returns the pulse-density stream.
interface delta_sigma_if #(
    parameter int BW = 14
);
    logic signed [BW-1:0] dac_i;
    logic                 dac_o;

    modport master (output dac_i, input  dac_o);
    modport slave  (input  dac_i, output dac_o);
endinterface

// File: rtl/delta_sigma.sv
// First-order delta-sigma (pulse-density) DAC: the carry out of a BW-bit
// accumulator fed with the offset-binary sample is the registered output bit.
module delta_sigma #(
    parameter int BW = 14
) (
    input  logic         clk_i,
    input  logic         rst_i,
    delta_sigma_if.slave ds
);

    logic [BW-1:0] u_d;
    logic [BW-1:0] u_q;
    logic [BW-1:0] acc_d;
    logic [BW-1:0] acc_q;
    logic          dac_d;
    logic          dac_q;
    logic [BW:0]   sum;

    // Inverting the MSB maps two's complement onto offset binary.
    always_comb begin
        u_d   = {~ds.dac_i[BW-1], ds.dac_i[BW-2:0]};
        sum   = {1'b0, acc_q} + {1'b0, u_q};
        acc_d = sum[BW-1:0];
        dac_d = sum[BW];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            u_q   <= '0;
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            u_q   <= u_d;
            acc_q <= acc_d;
            dac_q <= dac_d;
        end
    end

    assign ds.dac_o = dac_q;

endmodule

// File: tb/tb_delta_sigma.sv
// Bench for delta_sigma: a BW=14 and a BW=4 instance checked against an
// integer accumulator model through scoreboard queues plus directed checks.
module tb_delta_sigma;

    logic clk;
    logic rst_n;

    delta_sigma_if #(.BW(14)) if14 ();
    delta_sigma_if #(.BW(4))  if4 ();

    delta_sigma #(.BW(14)) dut14 (.clk_i(clk), .rst_i(rst_n), .ds(if14.slave));
    delta_sigma #(.BW(4))  dut4  (.clk_i(clk), .rst_i(rst_n), .ds(if4.slave));

    int n_chk = 0;
    int n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: plain integer accumulation, output bit = sum / 2^BW.
    int acc14_m, u14_m, acc4_m, u4_m;
    bit q14[$];
    bit q4[$];

    always @(posedge clk or negedge rst_n) begin
        int s;
        if (!rst_n) begin
            acc14_m = 0; u14_m = 0; acc4_m = 0; u4_m = 0;
            q14.delete();
            q4.delete();
        end else begin
            s = acc14_m + u14_m;
            q14.push_back(bit'(s / 16384));
            acc14_m = s % 16384;
            u14_m   = int'(if14.dac_i) + 8192;
            s = acc4_m + u4_m;
            q4.push_back(bit'(s / 16));
            acc4_m = s % 16;
            u4_m   = int'(if4.dac_i) + 8;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (q14.size() > 0) chk("sb14", 32'(if14.dac_o), 32'(q14.pop_front()));
            if (q4.size() > 0)  chk("sb4", 32'(if4.dac_o), 32'(q4.pop_front()));
        end else begin
            chk("rst14", 32'(if14.dac_o), 0);
            chk("rst4", 32'(if4.dac_o), 0);
        end
    end

    // Reset is asserted and released between edges; the next posedge is edge 1.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic count14(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(if14.dac_o);
        end
    endtask

    task automatic count4(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(if4.dac_o);
        end
    endtask

    initial begin
        int ones;
        int v;
        rst_n      = 1'b1;
        if14.dac_i = '0;
        if4.dac_i  = '0;
        #1 rst_n = 1'b0;

        // Midscale: 0 at edges 1-2, then 1 on odd edges.
        do_reset();
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            chk("mid", 32'(if14.dac_o), 32'((k >= 3 && k % 2 == 1) ? 1 : 0));
        end
        @(negedge clk);
        chk("pre_rst_one", 32'(if14.dac_o), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'(if14.dac_o), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("mid_rep", 32'(if14.dac_o), 32'((k >= 3 && k % 2 == 1) ? 1 : 0));
        end

        // Minimum code: output never goes high.
        if14.dac_i = -14'sd8192;
        do_reset();
        count14(2000, ones);
        chk("min_ones", 32'(ones), 0);

        // Maximum code: one zero per 2^14 window.
        if14.dac_i = 14'sd8191;
        do_reset();
        repeat (2) @(negedge clk);
        count14(16384, ones);
        chk("max_ones", 32'(ones), 16383);

        // Quarter scale: period 4, ones at edges 5, 9, ...
        if14.dac_i = -14'sd4096;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("quarter", 32'(if14.dac_o), 32'((k >= 2 && k % 4 == 1) ? 1 : 0));
        end
        count14(16384, ones);
        chk("quarter_ones", 32'(ones), 4096);

        // Random constants on the narrow instance, no reset between holds.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            v = int'($urandom_range(15)) - 8;
            if4.dac_i = 4'(v);
            repeat (2) @(negedge clk);
            count4(16, ones);
            chk("rand4_ones", 32'(ones), 32'(v + 8));
        end

        // Random constants on the wide instance.
        for (int i = 0; i < 2; i++) begin
            v = int'($urandom_range(16383)) - 8192;
            if14.dac_i = 14'(v);
            repeat (2) @(negedge clk);
            count14(16384, ones);
            chk("rand14_ones", 32'(ones), 32'(v + 8192));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
